// File: rtl/spm_boot_loader_pkg.sv
// Shared encodings for the RISC SPM boot loader: FSM states, memory mux select
// and small state-decode helpers.
package spm_boot_loader_pkg;

  typedef enum logic [2:0] {
    BL_IDLE   = 3'd0,
    BL_LOAD   = 3'd1,
    BL_SETTLE = 3'd2,
    BL_RUN    = 3'd3,
    BL_DONE   = 3'd4,
    BL_ERR    = 3'd5
  } bl_state_e;

  localparam logic SEL_MEM_LOADER = 1'b1;
  localparam logic SEL_MEM_CPU    = 1'b0;

  function automatic logic bl_is_busy(input bl_state_e s);
    return (s == BL_LOAD) || (s == BL_SETTLE) || (s == BL_RUN);
  endfunction

  // The CPU only comes out of reset once the program is in memory, and stays
  // released while parked on its halt instruction.
  function automatic logic bl_cpu_live(input bl_state_e s);
    return (s == BL_RUN) || (s == BL_DONE);
  endfunction

  function automatic logic bl_owns_mem(input bl_state_e s);
    return (s == BL_LOAD) || (s == BL_SETTLE);
  endfunction

endpackage

// File: rtl/spm_boot_loader_if.sv
// Byte stream input plus program-memory write port driven by the boot loader.
interface spm_boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    output s_data, s_valid,
    input  s_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/spm_boot_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module spm_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_max
);

  localparam logic [WIDTH-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] r_count;
  logic             w_max;

  assign w_max = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_max) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_count = r_count;
  assign o_max   = w_max;

endmodule

// File: rtl/spm_boot_loader.sv
// Boot sequencer: streams a program into SPM memory with the CPU held in reset,
// then releases the CPU and times its run until halt or timeout.
//   IDLE: parked, CPU reset   | LOAD: accept bytes, write mem | SETTLE: 1 cycle gap
//   RUN: CPU live, counting   | DONE: halted, CPU stays live  | ERR: timeout, CPU reset
module spm_boot_loader
  import spm_boot_loader_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter logic [15:0] MAX_RUN = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_cpu_halt,
  spm_boot_loader_if.slave  bus,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_run_cycles
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE = 1;

  bl_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_cpu_rst_n, r_mem_sel, r_busy, r_done, r_err;
  logic              w_start_ok, w_s_ready, w_hs, w_last, w_timeout, w_cnt_en, w_cnt_max;
  logic [15:0]       w_run_cycles;
  logic [ADDR_W:0]   w_len_ext;

  assign w_start_ok = i_start && !i_abort &&
                      ((r_state == BL_IDLE) || (r_state == BL_DONE) || (r_state == BL_ERR));
  assign w_s_ready  = (r_state == BL_LOAD);
  assign w_hs       = bus.s_valid && w_s_ready;
  assign w_last     = w_hs && (r_remaining == REM_ONE);
  assign w_timeout  = (w_run_cycles == MAX_RUN) || w_cnt_max;
  assign w_cnt_en   = (r_state == BL_RUN) && !i_cpu_halt && !i_abort && !w_timeout;
  // len of zero encodes a full 2^ADDR_W byte load
  assign w_len_ext  = {(i_len == '0), i_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BL_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      BL_IDLE:   if (w_start_ok) w_next = BL_LOAD;
      BL_LOAD:   if (w_last) w_next = BL_SETTLE;
      BL_SETTLE: w_next = BL_RUN;
      BL_RUN: begin
        if (i_cpu_halt)     w_next = BL_DONE;
        else if (w_timeout) w_next = BL_ERR;
      end
      BL_DONE, BL_ERR: if (w_start_ok) w_next = BL_LOAD;
      default:   w_next = BL_IDLE;
    endcase
    if (i_abort) w_next = BL_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_start_ok) begin
      r_ptr       <= i_base_addr;
      r_remaining <= w_len_ext;
    end else if (w_hs) begin
      r_ptr       <= r_ptr + PTR_ONE;
      r_remaining <= r_remaining - REM_ONE;
    end
  end

  // done/err survive an abort and are only cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rst_n <= 1'b0;
      r_mem_sel   <= SEL_MEM_CPU;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cpu_rst_n <= bl_cpu_live(w_next);
      r_mem_sel   <= bl_owns_mem(w_next) ? SEL_MEM_LOADER : SEL_MEM_CPU;
      r_busy      <= bl_is_busy(w_next);
      if (w_start_ok) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_next == BL_DONE) r_done <= 1'b1;
        if (w_next == BL_ERR)  r_err  <= 1'b1;
      end
    end
  end

  spm_sat_counter #(.WIDTH(16)) u_run_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_ok),
    .i_en    (w_cnt_en),
    .o_count (w_run_cycles),
    .o_max   (w_cnt_max)
  );

  assign bus.s_ready   = w_s_ready;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_addr  = r_ptr;
  assign bus.mem_we    = w_hs;
  assign bus.mem_wdata = w_hs ? bus.s_data : {DATA_W{1'b0}};
  assign o_cpu_rst_n   = r_cpu_rst_n;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_run_cycles  = w_run_cycles;

endmodule

// File: tb/tb_spm_boot_loader.sv
// Scoreboard bench for spm_boot_loader with a stub CPU that halts on an 0xF? opcode.
module tb_spm_boot_loader;

  localparam int          AW   = 8;
  localparam int          DW   = 8;
  localparam logic [15:0] MAXR = 16'd20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0;
  logic [7:0]  i_base_addr = 8'h00, i_len = 8'h00;
  logic        stub_halt = 1'b0, tb_halt = 1'b0;
  logic        w_halt;
  logic        o_cpu_rst_n, o_busy, o_done, o_err;
  logic [15:0] o_run_cycles;

  always #5 clk = ~clk;
  assign w_halt = stub_halt | tb_halt;

  spm_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spm_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_RUN(MAXR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_base_addr  (i_base_addr),
    .i_len        (i_len),
    .i_cpu_halt   (w_halt),
    .bus          (bus),
    .o_cpu_rst_n  (o_cpu_rst_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_run_cycles (o_run_cycles)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic d; logic e; logic [15:0] rc; } res_t;

  int         total = 0, bad = 0;
  int         nwrites = 0;
  int         cpu_base = 0;
  wr_t        exp_wr[$];
  res_t       exp_res[$];
  logic [7:0] sbytes[$];
  logic [7:0] model_mem[256];
  logic [7:0] phys_mem[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome from the program's point of view: CPU steps one byte per cycle from base
  // and halts on the first 0xF? opcode; with no halt by step MAXR it times out.
  function automatic res_t predict(input int base);
    res_t       r;
    logic [7:0] op;
    for (int k = 0; k <= int'(MAXR); k++) begin
      op = model_mem[(base + k) % 256];
      if (op[7:4] == 4'hF) begin
        r.d = 1'b1; r.e = 1'b0; r.rc = 16'(k);
        return r;
      end
    end
    r.d = 1'b0; r.e = 1'b1; r.rc = MAXR;
    return r;
  endfunction

  // Write monitor: owns the physical memory the stub CPU executes from.
  initial begin
    wr_t w;
    for (int i = 0; i < 256; i++) phys_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        nwrites++;
        chk("wr_mem_sel", 32'(bus.mem_sel), 1);
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got write %0h@%0h expected none", bus.mem_wdata, bus.mem_addr);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
          chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
        end
        phys_mem[bus.mem_addr] = bus.mem_wdata;
      end
    end
  end

  // Result monitor: compares on every busy 1->0 transition.
  initial begin
    logic pb;
    res_t r;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (pb === 1'b1 && o_busy === 1'b0) begin
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL res_unexpected: got done=%0b err=%0b expected no completion", o_done, o_err);
        end else begin
          r = exp_res.pop_front();
          chk("res_done", 32'(o_done), 32'(r.d));
          chk("res_err", 32'(o_err), 32'(r.e));
          chk("res_run_cycles", 32'(o_run_cycles), 32'(r.rc));
          chk("res_cpu_rst_n", 32'(o_cpu_rst_n), 32'(r.d));
        end
      end
      pb = o_busy;
    end
  end

  // Stub CPU.
  initial begin
    int         pc;
    bit         halted;
    logic [7:0] op;
    pc = 0; halted = 0;
    forever begin
      @(negedge clk);
      if (o_cpu_rst_n !== 1'b1) begin
        pc = cpu_base; halted = 0; stub_halt = 1'b0;
      end else if (stub_halt) begin
        stub_halt = 1'b0; halted = 1;
      end else if (!halted) begin
        op = phys_mem[pc % 256];
        if (op[7:4] == 4'hF) stub_halt = 1'b1;
        else                 pc = (pc + 1) % 256;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int n, input int hpos);
    logic [7:0] v;
    sbytes.delete();
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 239));
      if (i == hpos) v = {4'hF, v[3:0]};
      sbytes.push_back(v);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    i_start = 1'b1; i_base_addr = b; i_len = l;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Starts at posedge+1 and returns at posedge+1 after the run completes.
  task automatic run_load(input logic [7:0] b, input logic [7:0] l, input int gap,
                          input bit halt_settle, input bit start_mid);
    int  n, n0, t;
    wr_t w;
    n  = (l == 8'h00) ? 256 : int'(l);
    n0 = nwrites;
    cpu_base = int'(b);
    do_start(b, l);
    @(negedge clk);
    chk("start_s_ready", 32'(bus.s_ready), 1);
    chk("start_busy", 32'(o_busy), 1);
    chk("start_err_clr", 32'(o_err), 0);
    chk("start_done_clr", 32'(o_done), 0);
    chk("start_run_clr", 32'(o_run_cycles), 0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      w.a = 8'((int'(b) + i) % 256);
      w.d = sbytes[i];
      exp_wr.push_back(w);
      model_mem[w.a] = w.d;
      bus.s_valid = 1'b1; bus.s_data = w.d;
      if (start_mid && i == 1) begin
        i_start = 1'b1; i_base_addr = b ^ 8'h55; i_len = 8'd7;
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0; i_start = 1'b0;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_s_ready", 32'(bus.s_ready), 1);
          chk("gap_cpu_rst_n", 32'(o_cpu_rst_n), 0);
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    chk("settle_cpu_rst_n", 32'(o_cpu_rst_n), 0);
    chk("settle_mem_sel", 32'(bus.mem_sel), 1);
    chk("settle_s_ready", 32'(bus.s_ready), 0);
    chk("load_write_count", 32'(nwrites - n0), 32'(n));
    if (halt_settle) tb_halt = 1'b1;
    @(posedge clk); #1;
    tb_halt = 1'b0;
    @(negedge clk);
    chk("run_cpu_rst_n", 32'(o_cpu_rst_n), 1);
    chk("run_mem_sel", 32'(bus.mem_sel), 0);
    exp_res.push_back(predict(int'(b)));
    t = 0;
    while (o_busy === 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("run_finish", 32'(o_busy), 0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int len, hp;
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_cpu_rst_n", 32'(o_cpu_rst_n), 0);
    chk("rst_mem_sel", 32'(bus.mem_sel), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_run_cycles", 32'(o_run_cycles), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic load, no halt in reach -> timeout
    sbytes = '{8'hA1, 8'hB2, 8'hC3};
    run_load(8'h10, 8'd3, 0, 0, 0);
    // single HLT at 0x10
    sbytes = '{8'hF0};
    run_load(8'h10, 8'd1, 0, 0, 0);

    // abort together with start in DONE
    i_start = 1'b1; i_abort = 1'b1; i_base_addr = 8'h33; i_len = 8'd2;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    chk("abort_s_ready", 32'(bus.s_ready), 0);
    chk("abort_cpu_rst_n", 32'(o_cpu_rst_n), 0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_done_held", 32'(o_done), 1);
    @(posedge clk); #1;

    // stalled stream
    fill(2, 1);
    run_load(8'h80, 8'd2, 5, 0, 0);
    // start ignored mid-load, halt pulse ignored in SETTLE
    fill(3, 2);
    run_load(8'h40, 8'd3, 1, 1, 1);

    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 10);
      hp  = $urandom_range(0, len);
      fill(len, hp);
      run_load(8'($urandom_range(0, 255)), 8'(len), $urandom_range(0, 3), 0, 0);
    end

    // wrap with len=0
    fill(256, 7);
    run_load(8'hFE, 8'd0, 0, 0, 0);

    // async reset mid-load
    cpu_base = 'h60;
    do_start(8'h60, 8'd4);
    begin
      wr_t w;
      w.a = 8'h60; w.d = 8'h55;
      exp_wr.push_back(w);
    end
    bus.s_valid = 1'b1; bus.s_data = 8'h55;
    @(posedge clk); #1;
    bus.s_data = 8'h66;
    #2;
    chk("pre_rst_mem_we", 32'(bus.mem_we), 1);
    begin
      res_t r;
      r.d = 1'b0; r.e = 1'b0; r.rc = 16'h0000;
      exp_res.push_back(r);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(bus.mem_we), 0);
    chk("arst_s_ready", 32'(bus.s_ready), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk("arst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("arst_mem_sel", 32'(bus.mem_sel), 0);
    chk("arst_cpu_rst_n", 32'(o_cpu_rst_n), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    chk("arst_err", 32'(o_err), 0);
    chk("arst_run_cycles", 32'(o_run_cycles), 0);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("end_exp_wr_empty", 32'(exp_wr.size()), 0);
    chk("end_exp_res_empty", 32'(exp_res.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_boot_loader.md
# spm_boot_loader

Boot sequencer for the RISC SPM. It holds the CPU in reset while a byte stream is written into program memory at a chosen base address. It then releases the CPU, counts execution cycles until `halt`, and reports done, or error on timeout. It sits at top level beside the controller/datapath, and owns the memory write port through `mem_sel` while loading.

## Interface
- `ADDR_W`, 8: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 8: memory word / stream byte width.
- `MAX_RUN`, 16'hFFFF: run-cycle limit before timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; sampled in IDLE, DONE, ERR.
- `abort` in 1: forces return to IDLE from any state.
- `base_addr` in ADDR_W: first load address, latched on accepted `start`.
- `len` in ADDR_W: byte count, latched on accepted `start`; 0 means 2^ADDR_W.
- `s_data` in DATA_W: stream byte.
- `s_valid` in 1: stream byte valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `mem_sel` out 1: 1 means the loader drives the memory address and data mux.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out DATA_W: write data.
- `mem_we` out 1: write strobe.
- `cpu_rst_n` out 1: active-low reset to the CPU controller.
- `cpu_halt` in 1: the controller's `halt`.
- `busy` out 1: state is not IDLE, DONE or ERR.
- `done` out 1: the program halted normally.
- `err` out 1: run timeout.
- `run_cycles` out 16: cycles spent in RUN, saturating.

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → SETTLE after the last byte is accepted.
  - SETTLE → RUN after 1 cycle.
  - RUN → DONE on `cpu_halt`.
  - RUN → ERR when `run_cycles == MAX_RUN` with no halt.
  - DONE or ERR → LOAD on `start`.
  - Any state → IDLE on `abort`; `abort` has priority over every other event.
- Accepted `start` latches `base_addr` into `ptr` and `len` into `remaining`, and clears `run_cycles`, `done` and `err`.
- LOAD behaviour:
  - `s_ready=1` and `mem_sel=1`.
  - A handshake is `s_valid & s_ready`. It is combinationally gated: `mem_we=1`, `mem_addr=ptr`, `mem_wdata=s_data`.
  - On each handshake, `ptr` increments with wrap (0xFF→0x00) and `remaining` decrements.
  - The handshake with `remaining==1` is the last byte.
  - Stream stalls (`s_valid=0`) are unbounded; no timeout applies in LOAD.
- SETTLE: `mem_sel` stays 1, `mem_we=0`, `s_ready=0`, `cpu_rst_n` stays 0.
- RUN:
  - `cpu_rst_n=1` and `mem_sel=0`.
  - `run_cycles` increments every cycle, saturating at 16'hFFFF.
- DONE: `cpu_rst_n` stays 1 (CPU parked in its halt state) and `done=1`.
- ERR: `cpu_rst_n=0` and `err=1`.
- IDLE: `cpu_rst_n=0`, `mem_sel=0`, `s_ready=0`.
- Ignored events:
  - `start` while `busy`.
  - `s_valid` outside LOAD.
  - `cpu_halt` outside RUN.
- `abort` does not clear `run_cycles`, `done` or `err`; they hold until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE.
  - `cpu_rst_n=0`, `mem_sel=0`, `s_ready=0`, `mem_we=0`.
  - `mem_addr=0`, `mem_wdata=0`.
  - `busy=0`, `done=0`, `err=0`, `run_cycles=0`.
- Register source of each output:
  - `cpu_rst_n`, `mem_sel`, `busy`, `done`, `err` are registered decodes of the next state.
  - `s_ready` is a registered decode of the current state.
  - `mem_we` and `mem_wdata` are combinational from the handshake.
  - `mem_addr` is registered (it is `ptr`).
- Latency:
  - `start` at edge N puts LOAD and `s_ready=1` in effect from cycle N+1.
  - The last-byte handshake in cycle M gives SETTLE in M+1 and `cpu_rst_n=1` from M+2.
  - The CPU controller resets synchronously, so its first fetch edge is M+2.
- `cpu_halt` sampled high in RUN gives `done=1` the next cycle. `run_cycles` does not count the cycle the halt is seen.
- Reset asserted mid-operation returns to reset values immediately (asynchronously); partially loaded memory is left as is.

## Structure
- Add to the shared header `spm_head.v`:
  - state encodings `BL_IDLE`, `BL_LOAD`, `BL_SETTLE`, `BL_RUN`, `BL_DONE`, `BL_ERR` (3-bit).
  - mux select constant `SEL_MEM_LOADER`.
- Sub-module `spm_sat_counter` (WIDTH param, inputs `clr` and `en`, output `count`, plus a `max` flag) implements `run_cycles`.
- The top level instantiates the loader beside the controller and uses `mem_sel` to mux the memory address, data and write port.

## Test plan
- Basic load: `base_addr=8'h10`, `len=3`, bytes A1,B2,C3 back-to-back.
  - Writes land at 10,11,12.
  - `cpu_rst_n` rises 2 cycles after the C3 handshake.
  - A HLT program at 0x10 gives `done=1`, `err=0`.
- Stalled stream: `len=2`, `s_valid` low 5 cycles between bytes.
  - Exactly 2 `mem_we` pulses.
  - `s_ready` stays 1 through the gap.
  - `cpu_rst_n` stays 0 until 2 cycles after the last byte.
- Wrap and len=0: `base_addr=8'hFE`, `len=0`.
  - 256 writes at FE,FF,00,…,FD.
  - LOAD exits after the 256th handshake.
- Timeout: `MAX_RUN=20`, program never halts.
  - `err=1`, `run_cycles=20`, `cpu_rst_n=0`.
  - A following `start` clears `err` and enters LOAD.
- Priority and ignore:
  - `abort` together with `start` in DONE goes to IDLE.
  - `start` during LOAD is ignored: `remaining` and `ptr` are unchanged.
  - `cpu_halt` pulsed during SETTLE has no effect.
- Async reset mid-LOAD: assert `rst_n` low between clock edges.
  - Every output takes its reset value before the next edge.
  - `mem_we` deasserts immediately.
